// File: rtl/small_calculator_pkg.sv
// Shared types and codes for the small-calculator datapath: control-word layout,
// select/op codes, tracker states and the control-word classifier.
package small_calculator_pkg;

  localparam logic [1:0] S1_ZERO = 2'b00;
  localparam logic [1:0] S1_IN1  = 2'b01;
  localparam logic [1:0] S1_IN2  = 2'b10;
  localparam logic [1:0] S1_ALU  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_R3 = 2'd3;

  // 15-bit control word, MSB first
  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       done;
  } ctrl_word_t;

  typedef enum logic [1:0] {T_IDLE, T_L1, T_L2, T_OP} track_state_e;

  typedef enum logic [2:0] {CL_IDLE, CL_LD1, CL_LD2, CL_OP, CL_DN, CL_BAD} ctrl_class_e;

  // The write-address checks make the load/op classes mutually exclusive.
  function automatic ctrl_class_e classify(input ctrl_word_t cw);
    ctrl_class_e cl;
    cl = CL_BAD;
    if (!cw.we && !cw.done) begin
      cl = CL_IDLE;
    end else if (!cw.we && cw.done) begin
      cl = CL_DN;
    end else if (cw.wa == REG_R1 && cw.s1 == S1_IN1) begin
      cl = CL_LD1;
    end else if (cw.wa == REG_R2 && cw.s1 == S1_IN2) begin
      cl = CL_LD2;
    end else if (cw.wa == REG_R3 && cw.s1 == S1_ALU &&
                 cw.rea && cw.raa == REG_R1 && cw.reb && cw.rab == REG_R2) begin
      cl = CL_OP;
    end
    return cl;
  endfunction

endpackage

// File: rtl/small_calculator_alu.sv
// Combinational W-bit ALU; results wrap modulo 2^W, carry and borrow are dropped.
module small_calculator_alu
  import small_calculator_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/small_calculator_dp.sv
// Small-calculator datapath: 4-entry register file, ALU, captured result and a
// tracker that flags control words arriving out of LD1/LD2/OP/DN order.
module small_calculator_dp
  import small_calculator_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [1:0]   s1,
  input  logic [1:0]   wa,
  input  logic         we,
  input  logic [1:0]   raa,
  input  logic         rea,
  input  logic [1:0]   rab,
  input  logic         reb,
  input  logic [1:0]   c,
  input  logic         s2,
  input  logic         done,
  output logic [W-1:0] out,
  output logic         res_valid,
  output logic         seq_err
);

  ctrl_word_t   cw;
  ctrl_class_e  cls;

  logic [W-1:0] regs_q [4];
  logic [W-1:0] regs_d [4];
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  logic [W-1:0] alu_y;
  logic [W-1:0] wdata;

  logic [W-1:0] out_q, out_d;
  logic         res_valid_q, res_valid_d;
  logic         seq_err_q, seq_err_d;
  track_state_e track_q, track_d;
  logic         proto_err;

  assign cw  = '{s1: s1, wa: wa, we: we, raa: raa, rea: rea, rab: rab,
                 reb: reb, c: c, s2: s2, done: done};
  assign cls = classify(cw);

  // Reads see the pre-edge register contents, so a same-cycle write is invisible.
  assign rd_a = rea ? regs_q[raa] : '0;
  assign rd_b = reb ? regs_q[rab] : '0;

  small_calculator_alu #(.W(W)) u_alu (
    .a  (rd_a),
    .b  (rd_b),
    .op (c),
    .y  (alu_y)
  );

  always_comb begin
    wdata = '0;
    case (s1)
      S1_ZERO: wdata = '0;
      S1_IN1:  wdata = in1;
      S1_IN2:  wdata = in2;
      S1_ALU:  wdata = alu_y;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[wa] = wdata;
    end
  end

  always_comb begin
    out_d       = out_q;
    res_valid_d = done;
    if (done) begin
      out_d = s2 ? alu_y : '0;
    end
  end

  always_comb begin
    track_d   = track_q;
    seq_err_d = seq_err_q;
    proto_err = 1'b0;
    case (track_q)
      T_IDLE: begin
        if (cls == CL_LD1)       track_d = T_L1;
        else if (cls != CL_IDLE) proto_err = 1'b1;
      end
      T_L1: begin
        if (cls == CL_LD2) track_d = T_L2;
        else               proto_err = 1'b1;
      end
      T_L2: begin
        if (cls == CL_OP) track_d = T_OP;
        else              proto_err = 1'b1;
      end
      T_OP: begin
        if (cls == CL_DN) track_d = T_IDLE;
        else              proto_err = 1'b1;
      end
      default: proto_err = 1'b1;
    endcase
    // A violation resynchronises to idle; the word itself still executes.
    if (proto_err) begin
      track_d   = T_IDLE;
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      out_q       <= '0;
      res_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      track_q     <= T_IDLE;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out_q       <= out_d;
      res_valid_q <= res_valid_d;
      seq_err_q   <= seq_err_d;
      track_q     <= track_d;
    end
  end

  assign out       = out_q;
  assign res_valid = res_valid_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_small_calculator_dp.sv
// Self-checking bench for small_calculator_dp: directed scenarios plus randomized
// control words compared against a behavioural model of the calculator.
module tb_small_calculator_dp;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in1, in2;
  logic [1:0]   s1, wa, raa, rab, c;
  logic         we, rea, reb, s2, done;
  logic [W-1:0] out;
  logic         res_valid, seq_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: register contents, result, and position in LD1/LD2/OP/DN.
  int m_r [4];
  int m_out;
  int m_rv;
  int m_err;
  int m_pos;

  small_calculator_dp #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .s1(s1), .wa(wa), .we(we), .raa(raa), .rea(rea), .rab(rab), .reb(reb),
    .c(c), .s2(s2), .done(done),
    .out(out), .res_valid(res_valid), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int alu_model(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      default: r = a ^ b;
    endcase
    return r & ((1 << W) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_out = 0; m_rv = 0; m_err = 0; m_pos = 0;
  endtask

  // Advance the model by one clock using the currently applied word.
  task automatic model_step();
    int a, b, y, wd, cls, nxt;
    a = rea ? m_r[raa] : 0;
    b = reb ? m_r[rab] : 0;
    y = alu_model(a, b, int'(c));
    case (s1)
      2'd0: wd = 0;
      2'd1: wd = int'(in1);
      2'd2: wd = int'(in2);
      default: wd = y;
    endcase
    // class: 0 idle, 1 ld1, 2 ld2, 3 op, 4 dn, 5 other
    if (!we && !done) cls = 0;
    else if (!we && done) cls = 4;
    else if (wa == 1 && s1 == 1) cls = 1;
    else if (wa == 2 && s1 == 2) cls = 2;
    else if (wa == 3 && s1 == 3 && rea && raa == 1 && reb && rab == 2) cls = 3;
    else cls = 5;
    if (m_pos == 0 && cls == 0) nxt = 0;
    else if (m_pos == 0 && cls == 1) nxt = 1;
    else if (m_pos == 1 && cls == 2) nxt = 2;
    else if (m_pos == 2 && cls == 3) nxt = 3;
    else if (m_pos == 3 && cls == 4) nxt = 0;
    else begin
      nxt = 0;
      m_err = 1;
    end
    m_pos = nxt;
    if (done) m_out = s2 ? y : 0;
    m_rv = done ? 1 : 0;
    if (we) m_r[wa] = wd;
  endtask

  task automatic apply(input logic [1:0] i_s1, input logic [1:0] i_wa, input logic i_we,
                       input logic [1:0] i_raa, input logic i_rea,
                       input logic [1:0] i_rab, input logic i_reb,
                       input logic [1:0] i_c, input logic i_s2, input logic i_done);
    @(negedge clk);
    s1 = i_s1; wa = i_wa; we = i_we; raa = i_raa; rea = i_rea;
    rab = i_rab; reb = i_reb; c = i_c; s2 = i_s2; done = i_done;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic w_idle();          apply(2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask
  task automatic w_ld1();           apply(2'd1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask
  task automatic w_ld2();           apply(2'd2, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask
  task automatic w_op(input logic [1:0] op); apply(2'd3, 2'd3, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, op, 1'b0, 1'b0); endtask
  // DN reads R3 through the ALU (R3 + 0) so the stored OP result reaches out.
  task automatic w_dn();            apply(2'd0, 2'd0, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1); endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    in1 = a;
    in2 = b;
    w_ld1();
    w_ld2();
    w_op(op);
    w_dn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in1 = '0; in2 = '0;
    s1 = '0; wa = '0; we = 1'b0; raa = '0; rea = 1'b0; rab = '0; reb = 1'b0;
    c = '0; s2 = 1'b0; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 4'h0 || res_valid !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h rv=%b err=%b expected out=0 rv=0 err=0", out, res_valid, seq_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: out=%h rv=%b err=%b", out, res_valid, seq_err);
  endtask

  task automatic test_add();
    run_txn(4'd5, 4'd3, 2'b00);
    checks++;
    if (out !== 4'h8 || res_valid !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL add_5_3: out=%h rv=%b err=%b expected out=8 rv=1 err=0", out, res_valid, seq_err);
    end
    w_idle();
    checks++;
    if (out !== 4'h8 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_hold: out=%h rv=%b expected out=8 rv=0", out, res_valid);
    end
    $display("add: 5+3 -> out=%h", out);
  endtask

  task automatic test_sub_wrap();
    run_txn(4'd3, 4'd5, 2'b01);
    checks++;
    if (out !== 4'hE || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL sub_wrap: out=%h rv=%b expected out=e rv=1", out, res_valid);
    end
    $display("sub: 3-5 -> out=%h", out);
  endtask

  task automatic test_logic();
    run_txn(4'hC, 4'hA, 2'b10);
    checks++;
    if (out !== 4'h8) begin
      errors++;
      $display("FAIL and_op: out=%h expected 8", out);
    end
    $display("and: c&a -> out=%h", out);
    run_txn(4'hC, 4'hA, 2'b11);
    checks++;
    if (out !== 4'h6) begin
      errors++;
      $display("FAIL xor_op: out=%h expected 6", out);
    end
    $display("xor: c^a -> out=%h", out);
  endtask

  task automatic test_overflow();
    run_txn(4'd9, 4'd9, 2'b00);
    checks++;
    if (out !== 4'h2 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow: out=%h err=%b expected out=2 err=0", out, seq_err);
    end
    $display("overflow: 9+9 -> out=%h", out);
  endtask

  task automatic test_back_to_back();
    run_txn(4'd7, 4'd4, 2'b01);
    run_txn(4'd2, 4'd6, 2'b00);
    checks++;
    if (out !== 4'h8 || res_valid !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: out=%h rv=%b err=%b expected out=8 rv=1 err=0", out, res_valid, seq_err);
    end
    $display("back_to_back: out=%h err=%b", out, seq_err);
  endtask

  task automatic test_protocol_error();
    w_dn();
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_dn_in_idle: seq_err=%b expected 1", seq_err);
    end
    run_txn(4'd6, 4'd1, 2'b01);
    checks++;
    if (out !== 4'h5 || res_valid !== 1'b1 || seq_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_recover: out=%h rv=%b err=%b expected out=5 rv=1 err=1", out, res_valid, seq_err);
    end
    $display("protocol_error: err=%b out=%h", seq_err, out);
  endtask

  task automatic test_reset_mid();
    in1 = 4'd4; in2 = 4'd7;
    w_ld1();
    w_ld2();
    #2;
    rst_n = 1'b0;
    s1 = '0; wa = '0; we = 1'b0; raa = '0; rea = 1'b0; rab = '0; reb = 1'b0;
    c = '0; s2 = 1'b0; done = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out !== 4'h0 || res_valid !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h rv=%b err=%b expected out=0 rv=0 err=0", out, res_valid, seq_err);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Operands cleared by reset: OP with no loads would give 0, so also check R1/R2 via a full sequence.
    run_txn(4'd1, 4'd2, 2'b00);
    checks++;
    if (out !== 4'h3 || res_valid !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_then_add: out=%h rv=%b err=%b expected out=3 rv=1 err=0", out, res_valid, seq_err);
    end
    $display("reset_mid: out=%h err=%b", out, seq_err);
  endtask

  task automatic test_random();
    int n_bad;
    n_bad = 0;
    for (int i = 0; i < 300; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      in1 = W'($urandom);
      in2 = W'($urandom);
      if (pick < 8) begin
        case (m_pos)
          0: if (pick < 2) w_idle(); else w_ld1();
          1: w_ld2();
          2: w_op(2'($urandom));
          default: apply(2'd0, 2'($urandom), 1'b0, 2'($urandom), 1'($urandom),
                         2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1);
        endcase
      end else begin
        apply(2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      end
      checks++;
      if (int'(out) != m_out || int'(res_valid) != m_rv || int'(seq_err) != m_err) begin
        errors++;
        n_bad++;
        $display("FAIL random_%0d: out=%h rv=%b err=%b expected out=%h rv=%0d err=%0d",
                 i, out, res_valid, seq_err, m_out, m_rv, m_err);
      end
    end
    $display("random: 300 cycles, %0d discrepancies", n_bad);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_logic();
    test_overflow();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/small_calculator_dp.md
Name: small_calculator_dp

Overview:
- Datapath responder for the small-calculator control-unit interface.
- Each cycle it consumes the 15-bit control word fields (s1, wa, we, raa, rea, rab, reb, c, s2, done) and executes them on a 4-entry register file and a 4-function ALU.
- Registers the final result and tracks the expected control-word order, flagging protocol violations.
- Sits between the operand inputs and the result output, beside the control unit.

Parameters:
- W, 4, operand/register/result width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in1  input  W  operand 1
- in2  input  W  operand 2
- s1  input  2  write-data select: 00 zero, 01 in1, 10 in2, 11 ALU output
- wa  input  2  register-file write address
- we  input  1  register-file write enable
- raa  input  2  read port A address
- rea  input  1  read port A enable (0 forces port A data to 0)
- rab  input  2  read port B address
- reb  input  1  read port B enable (0 forces port B data to 0)
- c  input  2  ALU op: 00 A+B, 01 A-B, 10 A&B, 11 A^B
- s2  input  1  output select: 1 ALU output, 0 zero
- done  input  1  result-capture strobe
- out  output  W  registered result
- res_valid  output  1  one-cycle pulse, out just updated
- seq_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n=0): R0..R3=0, out=0, res_valid=0, seq_err=0, tracker=T_IDLE. Release takes effect on the next clk edge.
- Read ports are combinational: A = rea ? R[raa] : 0; B = reb ? R[rab] : 0.
- ALU is combinational, W-bit, modulo 2^W. Carry/borrow are discarded; SUB wraps (3-5 = 0xE for W=4).
- Write: on posedge with we=1, R[wa] <= mux(s1). Same-cycle read of the address being written returns the old value.
- Capture: on posedge with done=1, out <= (s2 ? ALU : 0) and res_valid <= 1. Otherwise res_valid <= 0 and out holds.
- Latency: result is visible on out one cycle after the DONE control word; it holds until the next capture or reset.
- Classifier decodes each cycle's control word into one class:
  - IDLE: we=0, done=0
  - LD1: we=1, wa=01, s1=01
  - LD2: we=1, wa=10, s1=10
  - OP: we=1, wa=11, s1=11, rea=1, raa=01, reb=1, rab=10
  - DN: done=1, we=0
  - BAD: any other word
- Tracker FSM, advanced on each posedge from the current class:
  - T_IDLE: IDLE stays; LD1 -> T_L1; anything else -> error
  - T_L1: LD2 -> T_L2; else error
  - T_L2: OP -> T_OP; else error
  - T_OP: DN -> T_IDLE; else error
  - error: set seq_err=1, tracker -> T_IDLE. Datapath still executes the word.
- seq_err stays high until rst_n. Back-to-back transactions (LD1 immediately after DN) are legal.
- Reset asserted mid-transaction: registers and out clear immediately. The next transaction must start at LD1.

Decomposition:
- Shared package small_calculator_pkg holds:
  - s1 select codes
  - ALU op codes
  - register-index constants
  - the 15-bit control-word field layout
  - tracker state enum T_IDLE/T_L1/T_L2/T_OP
  - control-class enum
- One natural sub-module: small_calculator_alu (combinational, W-bit, op-coded). Register file and tracker stay in the top.

Test Plan:
- Add (W=4): in1=5, in2=3, sequence LD1,LD2,OP(c=00),DN -> R1=5, R2=3, R3=8; out=8 with res_valid pulse one cycle after DN; seq_err=0.
- Sub wrap: in1=3, in2=5, c=01 -> out=0xE.
- Logic ops: in1=0xC, in2=0xA: c=10 -> out=0x8; c=11 -> out=0x6.
- Overflow: in1=9, in2=9, c=00 -> out=0x2.
- Protocol error: DN word while in T_IDLE -> seq_err=1 next cycle. A following legal LD1..DN still yields a correct out, and seq_err stays 1.
- Reset mid-transaction: rst_n low after LD2 -> out=0, R*=0, res_valid=0 asynchronously. A full new sequence with in1=1, in2=2 ADD -> out=3, seq_err=0.
